// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: bus-side output channel of the configurable UART receiver.
//   data_out        received data, right-justified, unused upper bits 0
//   rx_valid        holding register full
//   rx_ready        consumer accepts; transfer when rx_valid && rx_ready
//   parity_error    parity status of the held frame (valid while rx_valid)
//   frame_error     stop-bit status of the held frame (valid while rx_valid)
//   break_error     break status of the held frame (valid while rx_valid)
//   overflow_error  one-clk pulse when a completed frame is dropped
// master: the receiver side; slave: the consumer side.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_MAX = 8
);
    logic [DATA_MAX-1:0] data_out;
    logic                rx_valid;
    logic                rx_ready;
    logic                parity_error;
    logic                frame_error;
    logic                break_error;
    logic                overflow_error;

    modport master (
        output data_out,
        output rx_valid,
        output parity_error,
        output frame_error,
        output break_error,
        output overflow_error,
        input  rx_ready
    );

    modport slave (
        input  data_out,
        input  rx_valid,
        input  parity_error,
        input  frame_error,
        input  break_error,
        input  overflow_error,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with input synchroniser, 3-sample
// majority voting, 5..DATA_MAX data bits, none/even/odd parity, 1 or 2 stop bits,
// break detection and a valid/ready holding register.
//   clk             clock
//   reset_n         asynchronous active-low reset
//   baud_tick       oversample enable, OVERSAMPLE pulses per bit
//   serial_data_in  asynchronous serial line, idle high
//   rx_enable       receiver enable; 0 aborts any frame in progress
//   cfg_*           frame format, latched at start detection
//   rx_bus          output channel (data, valid/ready, status flags)
module uart_rx_cfg #(
    parameter int unsigned DATA_MAX    = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          baud_tick,
    input  logic                          serial_data_in,
    input  logic                          rx_enable,
    input  logic [$clog2(DATA_MAX+1)-1:0] cfg_data_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    uart_rx_cfg_if.master                 rx_bus
);
    localparam int unsigned CW = $clog2(DATA_MAX + 1);
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_MAX);

    localparam logic [SW-1:0] SmpLo   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SmpMid  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SmpHi   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SmpLast = SW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] BitsMin = CW'(5);
    localparam logic [CW-1:0] BitsMax = CW'(DATA_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_prev_q;
    state_e                 state_q;
    logic [SW-1:0]          smp_cnt_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [BW-1:0]          last_idx_q;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   stop2_q;
    logic [DATA_MAX-1:0]    shreg_q;
    logic                   par_bit_q;
    logic                   par_err_q;
    logic                   frm_err_q;
    logic [1:0]             smp_q;

    logic [DATA_MAX-1:0]    data_q;
    logic                   valid_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   berr_q;
    logic                   ovf_q;

    logic                   line;
    logic                   start_edge;
    logic                   at_hi;
    logic                   at_last;
    logic                   bit_val;
    logic [CW-1:0]          bits_clamped;
    logic [BW-1:0]          last_idx_d;
    logic                   brk_cond;
    logic                   done;
    logic                   done_brk;
    logic                   done_ferr;
    logic                   done_perr;

    always_comb begin
        line       = sync_q[SYNC_STAGES-1];
        start_edge = line_prev_q & ~line & rx_enable;
        at_hi      = baud_tick && (smp_cnt_q == SmpHi);
        at_last    = baud_tick && (smp_cnt_q == SmpLast);
        // 2-of-3 vote: two stored samples plus the line at the deciding tick
        bit_val    = (smp_q[0] & smp_q[1]) | (smp_q[0] & line) | (smp_q[1] & line);

        if (cfg_data_bits < BitsMin) begin
            bits_clamped = BitsMin;
        end else if (cfg_data_bits > BitsMax) begin
            bits_clamped = BitsMax;
        end else begin
            bits_clamped = cfg_data_bits;
        end
        last_idx_d = BW'(bits_clamped - CW'(1));

        brk_cond  = (shreg_q == '0) && !(par_en_q && par_bit_q) && !bit_val;
        // bit_cnt_q is 0 on the first stop bit and 1 on the second
        done      = rx_enable && (state_q == StStop) && at_hi &&
                    ((bit_cnt_q != '0) || !stop2_q || brk_cond);
        done_brk  = brk_cond && (bit_cnt_q == '0);
        done_ferr = !done_brk && (frm_err_q || !bit_val);
        done_perr = !done_brk && par_err_q;
    end

    // Receive FSM, synchroniser and bit timing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '1;
            line_prev_q <= 1'b1;
            state_q     <= StIdle;
            smp_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            last_idx_q  <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            shreg_q     <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            smp_q       <= 2'b11;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], serial_data_in};
            end
            line_prev_q <= line;

            if (baud_tick) begin
                smp_cnt_q <= (smp_cnt_q == SmpLast) ? '0 : smp_cnt_q + SW'(1);
                if (smp_cnt_q == SmpLo) begin
                    smp_q[0] <= line;
                end
                if (smp_cnt_q == SmpMid) begin
                    smp_q[1] <= line;
                end
            end

            if (!rx_enable) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_edge) begin
                            state_q    <= StStart;
                            smp_cnt_q  <= '0;
                            bit_cnt_q  <= '0;
                            last_idx_q <= last_idx_d;
                            par_en_q   <= cfg_parity_en;
                            par_odd_q  <= cfg_parity_odd;
                            stop2_q    <= cfg_stop2;
                            shreg_q    <= '0;
                            par_bit_q  <= 1'b0;
                            par_err_q  <= 1'b0;
                            frm_err_q  <= 1'b0;
                        end
                    end
                    StStart: begin
                        if (at_hi && bit_val) begin
                            state_q <= StIdle;
                        end else if (at_last) begin
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        if (at_hi) begin
                            shreg_q[bit_cnt_q] <= bit_val;
                        end
                        if (at_last) begin
                            if (bit_cnt_q == last_idx_q) begin
                                bit_cnt_q <= '0;
                                state_q   <= par_en_q ? StParity : StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                            end
                        end
                    end
                    StParity: begin
                        if (at_hi) begin
                            par_bit_q <= bit_val;
                            par_err_q <= bit_val != ((^shreg_q) ^ par_odd_q);
                        end
                        if (at_last) begin
                            state_q <= StStop;
                        end
                    end
                    StStop: begin
                        if (done) begin
                            state_q <= done_brk ? StBreakWait : StIdle;
                        end else if (at_hi) begin
                            frm_err_q <= !bit_val;
                        end else if (at_last) begin
                            bit_cnt_q <= BW'(1);
                        end
                    end
                    StBreakWait: begin
                        if (line) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Holding register and valid/ready handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            berr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (done) begin
                if (!valid_q || rx_bus.rx_ready) begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                    perr_q  <= done_perr;
                    ferr_q  <= done_ferr;
                    berr_q  <= done_brk;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (valid_q && rx_bus.rx_ready) begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                berr_q  <= 1'b0;
            end
        end
    end

    assign rx_bus.data_out       = data_q;
    assign rx_bus.rx_valid       = valid_q;
    assign rx_bus.parity_error   = perr_q;
    assign rx_bus.frame_error    = ferr_q;
    assign rx_bus.break_error    = berr_q;
    assign rx_bus.overflow_error = ovf_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg (DATA_MAX=8, OVERSAMPLE=16,
// baud_tick every clk so one bit is 16 clocks).
module tb_uart_rx_cfg;
    localparam int BitClks = 16;

    logic       clk;
    logic       reset_n;
    logic       baud_tick;
    logic       serial_data_in;
    logic       rx_enable;
    logic [3:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic       cfg_parity_odd;
    logic       cfg_stop2;

    uart_rx_cfg_if #(.DATA_MAX(8)) bus ();

    uart_rx_cfg #(
        .DATA_MAX   (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .baud_tick     (baud_tick),
        .serial_data_in(serial_data_in),
        .rx_enable     (rx_enable),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2     (cfg_stop2),
        .rx_bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       be;
    } cap_t;

    cap_t cap_q[$];
    int   ovf_cnt;
    int   n_checks;
    int   n_fail;

    // Record every completed handshake and every overflow pulse
    always @(negedge clk) begin
        if (bus.rx_valid && bus.rx_ready) begin
            cap_q.push_back({bus.data_out, bus.parity_error, bus.frame_error, bus.break_error});
        end
        if (bus.overflow_error) begin
            ovf_cnt++;
        end
    end

    typedef struct {
        logic [3:0] cfg_bits;
        bit         pen;
        bit         podd;
        bit         st2;
        int         nsend;
        logic [7:0] data;
        bit         pbit;
        bit         s1;
        bit         s2;
        logic [7:0] exp_d;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        serial_data_in = b;
        tick(BitClks);
    endtask

    task automatic send_frame(input int nbits, input logic [7:0] d, input bit pen,
                              input bit pb, input bit s1, input bit st2, input bit s2);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[i]);
        end
        if (pen) send_bit(pb);
        send_bit(s1);
        if (st2) send_bit(s2);
        serial_data_in = 1'b1;
    endtask

    task automatic wait_cap(input int n);
        int k;
        k = 0;
        while (cap_q.size() < n && k < 400) begin
            tick(1);
            k++;
        end
        check("capture_count", 32'(cap_q.size()), 32'(n));
    endtask

    task automatic set_cfg(input logic [3:0] nb, input bit pen, input bit podd, input bit st2);
        cfg_data_bits  = nb;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = st2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ovf_cnt  = 0;
        reset_n        = 1'b0;
        baud_tick      = 1'b1;
        serial_data_in = 1'b1;
        rx_enable      = 1'b1;
        bus.rx_ready   = 1'b1;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);

        //                cfg  pen podd st2 n  data   pb s1 s2 exp_d  pe fe
        vecs[0] = '{4'd8,  1'b0, 1'b0, 1'b0, 8, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{4'd7,  1'b1, 1'b0, 1'b1, 7, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        vecs[2] = '{4'd8,  1'b1, 1'b1, 1'b0, 8, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{4'd5,  1'b0, 1'b0, 1'b0, 5, 8'h1F, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
        vecs[4] = '{4'd3,  1'b0, 1'b0, 1'b0, 5, 8'h15, 1'b0, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0};
        vecs[5] = '{4'd15, 1'b0, 1'b0, 1'b0, 8, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[6] = '{4'd8,  1'b1, 1'b0, 1'b0, 8, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{4'd6,  1'b1, 1'b1, 1'b1, 6, 8'h2A, 1'b0, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b1};

        // Reset state
        tick(3);
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_flags", 32'({bus.parity_error, bus.frame_error, bus.break_error}), 32'd0);
        check("rst_ovf", 32'(bus.overflow_error), 32'd0);
        reset_n = 1'b1;
        tick(2 * BitClks);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            set_cfg(vecs[i].cfg_bits, vecs[i].pen, vecs[i].podd, vecs[i].st2);
            cap_q.delete();
            send_frame(vecs[i].nsend, vecs[i].data, vecs[i].pen, vecs[i].pbit,
                       vecs[i].s1, vecs[i].st2, vecs[i].s2);
            tick(2 * BitClks);
            wait_cap(1);
            if (cap_q.size() > 0) begin
                check($sformatf("vec%0d_data", i), 32'(cap_q[0].d), 32'(vecs[i].exp_d));
                check($sformatf("vec%0d_perr", i), 32'(cap_q[0].pe), 32'(vecs[i].exp_pe));
                check($sformatf("vec%0d_ferr", i), 32'(cap_q[0].fe), 32'(vecs[i].exp_fe));
                check($sformatf("vec%0d_berr", i), 32'(cap_q[0].be), 32'd0);
            end
        end

        // Break: all-zero frame, line stays low ~30 bit times, then a normal frame
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        cap_q.delete();
        serial_data_in = 1'b0;
        tick(30 * BitClks);
        serial_data_in = 1'b1;
        tick(2 * BitClks);
        check("brk_count", 32'(cap_q.size()), 32'd1);
        if (cap_q.size() > 0) begin
            check("brk_data", 32'(cap_q[0].d), 32'd0);
            check("brk_berr", 32'(cap_q[0].be), 32'd1);
            check("brk_ferr", 32'(cap_q[0].fe), 32'd0);
        end
        cap_q.delete();
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(2 * BitClks);
        wait_cap(1);
        if (cap_q.size() > 0) begin
            check("after_brk_data", 32'(cap_q[0].d), 32'h81);
            check("after_brk_berr", 32'(cap_q[0].be), 32'd0);
        end

        // Overflow: consumer stalled across two frames
        cap_q.delete();
        ovf_cnt      = 0;
        bus.rx_ready = 1'b0;
        send_frame(8, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(2 * BitClks);
        send_frame(8, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(2 * BitClks);
        check("ovf_pulses", 32'(ovf_cnt), 32'd1);
        check("ovf_valid", 32'(bus.rx_valid), 32'd1);
        check("ovf_data", 32'(bus.data_out), 32'h11);
        bus.rx_ready = 1'b1;
        tick(3);
        check("ovf_drain_valid", 32'(bus.rx_valid), 32'd0);
        check("ovf_drain_hold", 32'(bus.data_out), 32'h11);
        check("ovf_drain_count", 32'(cap_q.size()), 32'd1);
        if (cap_q.size() > 0) check("ovf_drain_data", 32'(cap_q[0].d), 32'h11);

        // Short low glitch while idle is rejected in START
        cap_q.delete();
        serial_data_in = 1'b0;
        tick(3);
        serial_data_in = 1'b1;
        tick(3 * BitClks);
        check("glitch_none", 32'(cap_q.size()), 32'd0);
        check("glitch_valid", 32'(bus.rx_valid), 32'd0);

        // Single-sample high spike on the middle vote of data bit 0
        cap_q.delete();
        send_bit(1'b0);
        serial_data_in = 1'b0;
        tick(9);
        serial_data_in = 1'b1;
        tick(1);
        serial_data_in = 1'b0;
        tick(6);
        for (int i = 1; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tick(2 * BitClks);
        wait_cap(1);
        if (cap_q.size() > 0) begin
            check("vote_data", 32'(cap_q[0].d), 32'h80);
            check("vote_ferr", 32'(cap_q[0].fe), 32'd0);
        end

        // rx_enable dropped mid-data discards the partial frame
        cap_q.delete();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx_enable = 1'b0;
        tick(5);
        serial_data_in = 1'b1;
        tick(2 * BitClks);
        rx_enable = 1'b1;
        tick(BitClks);
        send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(2 * BitClks);
        wait_cap(1);
        if (cap_q.size() > 0) check("en_data", 32'(cap_q[0].d), 32'h0F);
        tick(2 * BitClks);
        check("en_only_one", 32'(cap_q.size()), 32'd1);

        // Asynchronous reset mid-frame with the holding register full
        bus.rx_ready = 1'b0;
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(2 * BitClks);
        check("pre_rst_valid", 32'(bus.rx_valid), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(3);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_mid_data", 32'(bus.data_out), 32'd0);
        check("rst_mid_flags",
              32'({bus.parity_error, bus.frame_error, bus.break_error, bus.overflow_error}),
              32'd0);
        serial_data_in = 1'b1;
        tick(2);
        reset_n      = 1'b1;
        bus.rx_ready = 1'b1;
        cap_q.delete();
        tick(3 * BitClks);
        check("post_rst_quiet", 32'(cap_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver. It is the next generation of the single-format receiver in the serial block. It adds 5..DATA_MAX data bits, none/even/odd parity, 1 or 2 stop bits, an external oversample tick, an input synchroniser, 3-sample majority voting and a valid/ready output holding register. It sits between the pad-side serial input and the bus-side RX FIFO or register interface.

Parameters:
DATA_MAX, 8, maximum data bits per frame; must be >= 5.
OVERSAMPLE, 16, baud_tick pulses per bit; must be even and >= 8.
SYNC_STAGES, 2, flops in the serial_data_in synchroniser; must be >= 2.

Ports:
clk  input  1  clock; one clock domain.
reset_n  input  1  asynchronous active-low reset.
baud_tick  input  1  oversample enable, one clk wide; all bit timing advances only on it.
serial_data_in  input  1  asynchronous serial line, idle high.
rx_enable  input  1  receiver enable.
cfg_data_bits  input  $clog2(DATA_MAX+1)  data bits per frame, 5..DATA_MAX.
cfg_parity_en  input  1  enables the parity bit.
cfg_parity_odd  input  1  1 = odd parity, 0 = even parity.
cfg_stop2  input  1  1 = two stop bits.
data_out  output  DATA_MAX  received data, LSB-first on the line, right-justified, unused upper bits 0.
rx_valid  output  1  holding register full.
rx_ready  input  1  consumer accepts; the handshake completes when rx_valid && rx_ready.
parity_error  output  1  parity status of the held frame; valid while rx_valid.
frame_error  output  1  stop-bit status of the held frame; valid while rx_valid.
break_error  output  1  break status of the held frame; valid while rx_valid.
overflow_error  output  1  one-clk pulse when a completed frame is dropped.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchroniser flops 1.
- Synchroniser: serial_data_in passes through SYNC_STAGES flops before any use. "line" below means the synchronised value.
- States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- cfg_* is latched on start detection. cfg changes mid-frame are ignored. cfg_data_bits outside 5..DATA_MAX is clamped to the nearest legal value.
- IDLE: on a line 1->0 edge with rx_enable=1, clear sample_cnt and bit_cnt, then go to START.
- sample_cnt increments on each baud_tick and wraps OVERSAMPLE-1 -> 0.
- Majority sampling: the line is sampled at sample_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is decided at OVERSAMPLE/2+1 as the 2-of-3 majority.
- START: if the decided bit is 1, treat it as a glitch and return to IDLE with no flags. If it is 0, continue; at sample_cnt = OVERSAMPLE-1 go to DATA.
- DATA: shift each decided bit into data position bit_cnt. When bit_cnt reaches cfg_data_bits-1 and the bit ends, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: expected parity bit = ^data XOR cfg_parity_odd. A mismatch sets parity_err_int. When the bit ends, go to STOP.
- STOP, first bit: the decided bit must be 1.
  - If cfg_stop2=1, wait to the next bit's midpoint and check that bit too.
  - Any 0 stop bit sets frame_err_int.
  - The frame completes at the final stop decision; it does not wait for the bit end.
- Break: break applies when all data bits are 0, the parity bit (if present) is 0, and the first stop bit is 0. Then break_error=1, frame_error=0, and the FSM goes to BREAK_WAIT. BREAK_WAIT goes to IDLE on the first line=1.
- Otherwise the FSM goes to IDLE after completion. A start edge on the very next cycle is accepted, so back-to-back frames are supported.
- Completion, holding register empty (or being emptied in the same cycle by the handshake): load data_out and the three error flags; rx_valid=1 on the next clk.
- Completion, holding register full and rx_ready=0: drop the new frame, keep the old data and flags, and pulse overflow_error for one clk on the next clk.
- Handshake with no simultaneous completion: rx_valid and all three error flags clear on the next clk. data_out holds its value.
- rx_enable=0: FSM forced to IDLE and any in-progress frame is discarded silently. The holding register and handshake keep operating.
- Reset mid-frame returns everything to the reset state immediately (asynchronous).
- Counter widths: sample_cnt is $clog2(OVERSAMPLE); bit_cnt is $clog2(DATA_MAX).

Test Plan:
- 8N1, OVERSAMPLE=16, baud_tick every clk, frame 0xA5, rx_ready=1 -> rx_valid pulses once, data_out=0xA5, all errors 0.
- 7E2 (cfg_data_bits=7, parity_en=1, odd=0, stop2=1), send 0x55 with parity bit 1 -> data_out=0x55, parity_error=1.
- 8O1, frame 0x3C with correct parity, stop bit forced 0 -> frame_error=1, break_error=0. Line held low 30 bit times after an all-zero frame -> break_error=1, one frame only, next frame 0x81 after line returns high is received correctly.
- rx_ready=0, two frames 0x11 then 0x22 -> overflow_error pulses once, data_out stays 0x11. Raise rx_ready -> rx_valid drops, no new data.
- 3-tick-wide low glitch while idle -> no rx_valid. Single-sample 1 glitch at a data-bit midpoint -> bit still decoded as 0 by majority.
- Deassert rx_enable mid-data, then reassert and send 0x0F -> only 0x0F is delivered. Assert reset_n=0 mid-frame -> all outputs 0 immediately.
